rls_rotate_seq: RTL

Iterative rotation sequencer that sits directly upstream of the RLS rotate-left stage in the DT engine and closes the loop around it. It accepts one word plus an arbitrary rotation amount, then decomposes the amount into power-of-two passes of 1, 2 or 4. It drives one RLS pass per set bit, LSB first, and feeds each RLS result back as the next pass's input. When all passes are done it presents the fully rotated word on a valid/ready output to the cluster-distribution logic.

---
 rtl/rls_rotate_seq_if.sv | 28 ++
 rtl/rls_rotate_seq.sv | 69 ++++++
 2 files changed

// File: rtl/rls_rotate_seq_if.sv
// Handshake and RLS-loop bundle for the rotation sequencer.
// slave is the sequencer's view; master is the environment (upstream, consumer, RLS).
interface rls_rotate_seq_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_WIDTH_BITS = 3
);
   logic                       in_valid;
   logic                       in_ready;
   logic [DATA_WIDTH-1:0]      in_data;
   logic [DATA_WIDTH_BITS-1:0] in_rot;
   logic [DATA_WIDTH-1:0]      rls_data_in;
   logic                       rls_shift_enable;
   logic [DATA_WIDTH_BITS-1:0] rls_shift_count;
   logic [DATA_WIDTH-1:0]      rls_data_out;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_WIDTH-1:0]      out_data;

   modport slave (
      input  in_valid, in_data, in_rot, rls_data_out, out_ready,
      output in_ready, rls_data_in, rls_shift_enable, rls_shift_count, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, in_rot, rls_data_out, out_ready,
      input  in_ready, rls_data_in, rls_shift_enable, rls_shift_count, out_valid, out_data
   );
endinterface

// File: rtl/rls_rotate_seq.sv
// Iterative rotate-left sequencer: splits the amount into power-of-two RLS passes,
// LSB first, looping each RLS result back until the word is fully rotated.
module rls_rotate_seq #(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_WIDTH_BITS = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rls_rotate_seq_if.slave      bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e                     state_q, state_d;
   logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
   logic [DATA_WIDTH_BITS-1:0] rem_q, rem_d;
   logic [DATA_WIDTH_BITS-1:0] rem_lsb;

   // Isolate the lowest set bit: this is the one-hot shift_count of the next pass.
   assign rem_lsb = rem_q & (~rem_q + DATA_WIDTH_BITS'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wdata_q <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         wdata_q <= wdata_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wdata_d = wdata_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: if (bus.in_valid) begin
            wdata_d = bus.in_data;
            rem_d   = bus.in_rot;
            state_d = ISSUE;
         end
         ISSUE: begin
            if (rem_q == '0) begin
               state_d = DONE;
            end else begin
               rem_d   = rem_q & ~rem_lsb;
               state_d = WAIT;
            end
         end
         // RLS registers its result, so it is only meaningful one cycle after issue.
         WAIT: begin
            wdata_d = bus.rls_data_out;
            state_d = ISSUE;
         end
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready         = (state_q == IDLE);
      bus.out_valid        = (state_q == DONE);
      bus.out_data         = wdata_q;
      bus.rls_data_in      = wdata_q;
      bus.rls_shift_enable = (state_q == ISSUE) && (rem_q != '0);
      bus.rls_shift_count  = bus.rls_shift_enable ? rem_lsb : '0;
   end
endmodule
